// File: rtl/aes_dec_key_sched.sv
// ---------------------------------------------------------------------------
// aes_dec_key_sched
//   Decryption-side AES-128 key schedule. A loaded cipher key is expanded
//   forward, one round per clock, up to the round-10 key. The schedule is
//   then walked backwards one round per `next` pulse (10, 9, ... 0). This
//   matches the order in which the inverse cipher consumes round keys.
//   Four aes_sbox instances implement SubWord. The forward and backward
//   steps share them through a mux on the word that is substituted.
//
// Ports
//   clk     in   1    rising-edge clock
//   rst     in   1    synchronous reset, active-high
//   ld      in   1    capture `key` and start forward expansion (wins over next)
//   key     in   KW   cipher key, word0 = key[127:96]
//   next    in   1    step kout back one round while READY and rnd > 0
//   kout    out  KW   round key for round index rnd
//   rnd     out  4    round index of kout
//   kvalid  out  1    kout/rnd valid (READY)
//   busy    out  1    forward expansion in progress
//   done    out  1    READY and rnd == 0 (kout equals the loaded key)
// ---------------------------------------------------------------------------

// AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// The S-box is computed instead of tabulated, so the source stays short.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8). Zero maps to zero, as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        d   = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
endmodule

module aes_dec_key_sched #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [KW-1:0] key,
    input  logic          next,
    output logic [KW-1:0] kout,
    output logic [3:0]    rnd,
    output logic          kvalid,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t        state, state_nxt;
    logic [KW-1:0] kreg, kreg_nxt;
    logic [3:0]    rcnt, rcnt_nxt;   // rcon index in EXPAND, round index in READY

    logic [31:0] k0, k1, k2, k3;
    logic [31:0] p1, p2, p3;
    logic [31:0] sel_word, rot_word, sub_word, t;
    logic [KW-1:0] fwd_key, bwd_key;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign {k0, k1, k2, k3} = kreg;

    // Words of the previous round key that can be recovered without the S-box.
    assign p3 = k3 ^ k2;
    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;

    // The forward step substitutes k3. The backward step substitutes the
    // recovered previous k3 (p3). Only one of the two is active at a time.
    assign sel_word = (state == EXPAND) ? k3 : p3;
    assign rot_word = {sel_word[23:0], sel_word[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot_word[8*b +: 8]),
            .d (sub_word[8*b +: 8])
        );
    end

    assign t = sub_word ^ {rcon(rcnt), 24'h0};

    always_comb begin
        logic [31:0] n0, n1, n2, n3;
        n0      = k0 ^ t;
        n1      = k1 ^ n0;
        n2      = k2 ^ n1;
        n3      = k3 ^ n2;
        fwd_key = {n0, n1, n2, n3};
        bwd_key = {k0 ^ t, p1, p2, p3};
    end

    // NOTE: registers use non-blocking assignments only; all next-state
    // values are computed combinationally below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kreg  <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            kreg  <= kreg_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // NOTE: every signal gets a hold default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        kreg_nxt  = kreg;
        rcnt_nxt  = rcnt;

        if (ld) begin
            // A load restarts from any state and overrides a concurrent next.
            state_nxt = EXPAND;
            kreg_nxt  = key;
            rcnt_nxt  = 4'd1;
        end else begin
            case (state)
                EXPAND: begin
                    kreg_nxt = fwd_key;
                    if (rcnt == LAST_RND) begin
                        state_nxt = READY;
                    end else begin
                        rcnt_nxt = rcnt + 4'd1;
                    end
                end
                READY: begin
                    if (next && (rcnt != 4'd0)) begin
                        kreg_nxt = bwd_key;
                        rcnt_nxt = rcnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign kout   = kreg;
    assign rnd    = rcnt;
    assign kvalid = (state == READY);
    assign busy   = (state == EXPAND);
    assign done   = (state == READY) && (rcnt == 4'd0);
endmodule
